fetch_thread_sequencer_mt: RTL

Multithreaded fetch front end. It sits directly upstream of the multithreaded instruction cache and downstream of the branch/exception redirect path. It holds one PC per hardware thread and picks one eligible thread per cycle round-robin. It issues that thread's PC to the I$ and, on a same-cycle hit, extracts the 32-bit instruction word from the returned line and registers it towards decode.

---
 rtl/fetch_thread_sequencer_mt_pkg.sv | 30 +++
 rtl/fetch_thread_sequencer_mt_rr_arbiter.sv | 42 ++++
 rtl/fetch_thread_sequencer_mt.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_thread_sequencer_mt_pkg.sv
// Shared types and constants for the multithreaded fetch front end.
// Default widths here match the fetch top-level parameter defaults.
package fetch_thread_sequencer_mt_pkg;

    localparam int FETCH_NUM_THREADS = 4;
    localparam int FETCH_ADDR_WIDTH  = 32;
    localparam int FETCH_LINE_WIDTH  = 128;
    localparam int FETCH_INSTR_WIDTH = 32;
    localparam int FETCH_TID_WIDTH   = $clog2(FETCH_NUM_THREADS);

    localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_BOOT_ADDR = 32'h0000_1000;

    // PC bits that pick the instruction word inside an I$ line.
    localparam int ICACHE_WORD_SEL_LSB = $clog2(FETCH_INSTR_WIDTH / 8);
    localparam int ICACHE_WORD_SEL_MSB = $clog2(FETCH_LINE_WIDTH / 8) - 1;

    typedef struct packed {
        logic                         valid;
        logic [FETCH_INSTR_WIDTH-1:0] data;
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
        logic [FETCH_TID_WIDTH-1:0]   thread_id;
    } fetch_instr_t;

    typedef struct packed {
        logic                        valid;
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_TID_WIDTH-1:0]  thread_id;
    } fetch_xcpt_t;

endpackage

// File: rtl/fetch_thread_sequencer_mt_rr_arbiter.sv
// Round-robin arbiter: searches from an internal pointer, and on an enabled
// grant moves the pointer to one past the winner.
module fetch_thread_sequencer_mt_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] ptr_ff;

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand         = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_ff) + i) % NUM_REQ);
            if (!grant_any && req[cand]) begin
                grant_any          = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_ff <= '0;
        end else if (advance && grant_any) begin
            ptr_ff <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_thread_sequencer_mt.sv
// Multithreaded fetch front end: per-thread PCs, round-robin I$ issue,
// same-cycle hit word extraction into a registered decode-facing slot.
module fetch_thread_sequencer_mt
    import fetch_thread_sequencer_mt_pkg::*;
#(
    parameter int                    NUM_THREADS = FETCH_NUM_THREADS,
    parameter int                    ADDR_WIDTH  = FETCH_ADDR_WIDTH,
    parameter int                    LINE_WIDTH  = FETCH_LINE_WIDTH,
    parameter int                    INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = FETCH_BOOT_ADDR,
    localparam int                   TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_active,
    input  logic [NUM_THREADS-1:0] icache_ready,
    output logic [ADDR_WIDTH-1:0]  icache_req_addr,
    output logic                   icache_req_valid,
    output logic [TID_W-1:0]       icache_req_thread_id,
    input  logic [LINE_WIDTH-1:0]  icache_rsp_data,
    input  logic                   icache_rsp_valid,
    input  logic                   icache_xcpt_bus_error,
    input  logic [TID_W-1:0]       icache_xcpt_thread_id,
    input  logic                   redirect_valid,
    input  logic [TID_W-1:0]       redirect_thread_id,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   decode_stall,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [TID_W-1:0]       instr_thread_id,
    output logic                   xcpt_fetch_valid,
    output logic [ADDR_WIDTH-1:0]  xcpt_fetch_pc,
    output logic [TID_W-1:0]       xcpt_fetch_thread_id
);

    localparam int WORD_LSB = ICACHE_WORD_SEL_LSB;
    localparam int WORD_MSB = $clog2(LINE_WIDTH / 8) - 1;

    logic [ADDR_WIDTH-1:0]  pc_ff [NUM_THREADS];
    logic [NUM_THREADS-1:0] halted_ff;
    fetch_instr_t           instr_ff;
    fetch_xcpt_t            xcpt_ff;

    logic [NUM_THREADS-1:0]   redirect_hit;
    logic [NUM_THREADS-1:0]   xcpt_hit;
    logic [NUM_THREADS-1:0]   eligible;
    logic [NUM_THREADS-1:0]   grant_onehot;
    logic [TID_W-1:0]         sel;
    logic                     any_eligible;
    logic                     issue;
    logic                     hit;
    logic [ADDR_WIDTH-1:0]    sel_pc;
    logic [WORD_MSB:WORD_LSB] word_idx;
    logic [INSTR_WIDTH-1:0]   word;

    always_comb begin
        redirect_hit = '0;
        xcpt_hit     = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            redirect_hit[t] = redirect_valid && (redirect_thread_id == TID_W'(t));
            xcpt_hit[t]     = icache_xcpt_bus_error && (icache_xcpt_thread_id == TID_W'(t));
        end
    end

    // A thread being redirected this cycle would fetch down the stale path.
    assign eligible = thread_active & icache_ready & ~halted_ff & ~redirect_hit;

    fetch_thread_sequencer_mt_rr_arbiter #(
        .NUM_REQ (NUM_THREADS)
    ) u_rr_arbiter (
        .clock        (clock),
        .reset        (reset),
        .req          (eligible),
        .advance      (issue),
        .grant_onehot (grant_onehot),
        .grant_idx    (sel),
        .grant_any    (any_eligible)
    );

    assign issue    = any_eligible && !decode_stall && !reset;
    assign hit      = issue && icache_rsp_valid;
    assign sel_pc   = pc_ff[sel];
    assign word_idx = sel_pc[WORD_MSB:WORD_LSB];
    assign word     = icache_rsp_data[int'(word_idx)*INSTR_WIDTH +: INSTR_WIDTH];

    assign icache_req_valid     = issue;
    assign icache_req_addr      = sel_pc;
    assign icache_req_thread_id = sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_ff[t] <= BOOT_ADDR;
            end
            halted_ff <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_hit[t]) begin
                    pc_ff[t] <= redirect_pc;
                end else if (hit && grant_onehot[t]) begin
                    pc_ff[t] <= pc_ff[t] + ADDR_WIDTH'(4);
                end
                // Redirect wins over a same-cycle bus error on the same thread.
                if (redirect_hit[t]) begin
                    halted_ff[t] <= 1'b0;
                end else if (xcpt_hit[t]) begin
                    halted_ff[t] <= 1'b1;
                end
            end
        end
    end

    // Unstalled, the slot is always rewritten, which also squashes any
    // instruction of a thread redirected in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_ff <= '0;
        end else if (!decode_stall) begin
            instr_ff.valid <= hit;
            if (hit) begin
                instr_ff.data      <= word;
                instr_ff.pc        <= sel_pc;
                instr_ff.thread_id <= sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            xcpt_ff <= '0;
        end else begin
            xcpt_ff.valid <= icache_xcpt_bus_error;
            if (icache_xcpt_bus_error) begin
                xcpt_ff.pc        <= pc_ff[icache_xcpt_thread_id];
                xcpt_ff.thread_id <= icache_xcpt_thread_id;
            end
        end
    end

    assign instr_valid          = instr_ff.valid;
    assign instr_data           = instr_ff.data;
    assign instr_pc             = instr_ff.pc;
    assign instr_thread_id      = instr_ff.thread_id;
    assign xcpt_fetch_valid     = xcpt_ff.valid;
    assign xcpt_fetch_pc        = xcpt_ff.pc;
    assign xcpt_fetch_thread_id = xcpt_ff.thread_id;

endmodule
